// File: rtl/alu_ex_pkg.sv
// Shared opcode encodings, flag bit positions and STR sequencing states for the execute stage.
package alu_ex_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_PUSH      = 5'd0;
  localparam logic [OPC_W-1:0] OP_POP       = 5'd1;
  localparam logic [OPC_W-1:0] OP_SUB_SP    = 5'd2;
  localparam logic [OPC_W-1:0] OP_CMP       = 5'd3;
  localparam logic [OPC_W-1:0] OP_MOVS      = 5'd4;
  localparam logic [OPC_W-1:0] OP_MOV       = 5'd5;
  localparam logic [OPC_W-1:0] OP_LDR       = 5'd6;
  localparam logic [OPC_W-1:0] OP_STR       = 5'd7;
  localparam logic [OPC_W-1:0] OP_LDR_NOP   = 5'd8;
  localparam logic [OPC_W-1:0] OP_ADD_SP    = 5'd9;
  localparam logic [OPC_W-1:0] OP_BRANCH_NC = 5'd10;
  localparam logic [OPC_W-1:0] OP_ADDS_3OP  = 5'd11;
  localparam logic [OPC_W-1:0] OP_BRANCH_C  = 5'd12;
  localparam logic [OPC_W-1:0] OP_STRB      = 5'd13;
  localparam logic [OPC_W-1:0] OP_LDRB      = 5'd14;
  localparam logic [OPC_W-1:0] OP_ADDS_2OP  = 5'd15;
  localparam logic [OPC_W-1:0] OP_NOP       = 5'd16;

  // Flag vector layout {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BEAT2 = 1'b1
  } str_state_e;

  // Memory-side attributes of an opcode
  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic byte_acc;
  } mem_ctrl_t;

  function automatic mem_ctrl_t mem_ctrl_of(input logic [OPC_W-1:0] op);
    mem_ctrl_t m;
    m.mem_rd   = (op == OP_LDR) || (op == OP_LDR_NOP) || (op == OP_LDRB) || (op == OP_POP);
    m.mem_wr   = (op == OP_STR) || (op == OP_STRB) || (op == OP_PUSH);
    m.byte_acc = (op == OP_LDRB) || (op == OP_STRB);
    return m;
  endfunction

endpackage

// File: rtl/alu_ex_flags.sv
// Combinational add/subtract with full N/Z/C/V; C on subtract means "no borrow".
module alu_ex_flags
  import alu_ex_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] res,
  output logic [3:0]        flags
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;

  // Subtract as a + ~b + 1 so carry-out and overflow share one adder
  always_comb begin
    b_eff         = sub ? ~b : b;
    sum           = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
    res           = sum[DATA_W-1:0];
    flags         = 4'b0000;
    flags[FLAG_N] = res[DATA_W-1];
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = sum[DATA_W];
    flags[FLAG_V] = (a[DATA_W-1] == b_eff[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
  end

endmodule

// File: rtl/alu_ex_pipe.sv
// Execute stage: one registered output slot with valid/ready, sync flush,
// branch resolution and two-beat STR sequencing.
// state    | meaning
// ST_IDLE  | accepting new ops when the output slot is free or draining
// ST_BEAT2 | STR in flight; beat 1 held or beat 2 waiting for acceptance
module alu_ex_pipe
  import alu_ex_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int OP_W   = 5   // must be >= OPC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [3:0]        in_flags,
  input  logic [REG_AW-1:0] in_wreg_loc,
  input  logic              in_wreg_en,
  input  logic [DATA_W-1:0] in_st_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic [REG_AW-1:0] out_wreg_loc,
  output logic              out_wreg_en,
  output logic [DATA_W-1:0] out_st_data,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              out_byte_lane,
  output logic              out_beat2,
  output logic              branch_taken
);

  localparam int BEAT_STEP = DATA_W / 8;

  str_state_e        state_q, state_d;
  logic [OPC_W-1:0]  op_id;
  logic              xfer;
  logic              out_fire;
  logic              beat2_load;
  mem_ctrl_t         mc;

  logic [DATA_W-1:0] fu_res;
  logic [3:0]        fu_flags;
  logic              fu_sub;
  logic [DATA_W-1:0] sum_ab;
  logic [DATA_W-1:0] ldr_addr;
  logic [DATA_W-1:0] beat2_addr_q;

  logic [DATA_W-1:0] nx_result;
  logic [DATA_W-1:0] nx_st_data;
  logic [3:0]        nx_flags;
  logic              nx_wreg_en;
  logic              nx_lane;
  logic              nx_taken;

  // Anything beyond the defined opcode range behaves as NOP
  assign op_id      = (in_op <= OP_W'(OP_NOP)) ? OPC_W'(in_op) : OP_NOP;
  assign mc         = mem_ctrl_of(op_id);
  assign xfer       = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign beat2_load = (state_q == ST_BEAT2) && out_valid && !out_beat2 && out_ready;

  assign fu_sub   = (op_id == OP_CMP);
  assign sum_ab   = in_a + in_b;
  assign ldr_addr = (in_pc + in_b + DATA_W'(4)) & ~DATA_W'(3);

  alu_ex_flags #(.DATA_W(DATA_W)) u_flags (
    .a     (in_a),
    .b     (in_b),
    .sub   (fu_sub),
    .res   (fu_res),
    .flags (fu_flags)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: enter BEAT2 on STR transfer, leave once beat 2 is accepted
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (xfer && (op_id == OP_STR)) state_d = ST_BEAT2;
        ST_BEAT2: if (out_valid && out_beat2 && out_ready) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM output: accept only when idle and the output slot frees this cycle
  always_comb begin
    in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
  end

  // Per-op result, flags and write-enable for the incoming op
  always_comb begin
    nx_result  = '0;
    nx_st_data = '0;
    nx_flags   = in_flags;
    nx_wreg_en = in_wreg_en;
    nx_lane    = 1'b0;
    nx_taken   = 1'b0;
    case (op_id)
      OP_PUSH:      begin nx_result = in_a - DATA_W'(1); nx_st_data = in_st_data; end
      OP_POP:       nx_result = in_a + DATA_W'(1);
      OP_SUB_SP:    nx_result = in_a - in_b;
      OP_ADD_SP:    nx_result = sum_ab;
      OP_ADDS_2OP,
      OP_ADDS_3OP:  begin nx_result = fu_res; nx_flags = fu_flags; end
      OP_CMP:       begin nx_result = fu_res; nx_flags = fu_flags; nx_wreg_en = 1'b0; end
      OP_MOV:       nx_result = in_a;
      OP_MOVS:      nx_result = in_b;
      OP_LDR:       nx_result = ldr_addr;
      OP_LDR_NOP:   nx_result = sum_ab;
      OP_LDRB:      begin nx_result = sum_ab & ~DATA_W'(1); nx_lane = sum_ab[0]; end
      OP_STRB:      begin
                      nx_result  = sum_ab & ~DATA_W'(1);
                      nx_lane    = sum_ab[0];
                      nx_st_data = in_c;
                    end
      OP_STR:       begin nx_result = sum_ab; nx_st_data = in_st_data; end
      OP_BRANCH_NC: begin nx_result = in_a; nx_taken = 1'b1; end
      OP_BRANCH_C:  begin nx_result = in_a; nx_taken = !in_flags[FLAG_Z]; end
      default:      nx_wreg_en = 1'b0;
    endcase
  end

  // Beat-2 address is captured with the STR so upstream may change operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                beat2_addr_q <= '0;
    else if (xfer && (op_id == OP_STR))     beat2_addr_q <= sum_ab + DATA_W'(BEAT_STEP);
  end

  // Output slot: flush > new transfer > STR beat 2 > drain; otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_flags     <= '0;
      out_wreg_loc  <= '0;
      out_wreg_en   <= 1'b0;
      out_st_data   <= '0;
      out_mem_rd    <= 1'b0;
      out_mem_wr    <= 1'b0;
      out_byte_lane <= 1'b0;
      out_beat2     <= 1'b0;
      branch_taken  <= 1'b0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_beat2    <= 1'b0;
      branch_taken <= 1'b0;
    end else if (xfer) begin
      out_valid     <= 1'b1;
      out_result    <= nx_result;
      out_flags     <= nx_flags;
      out_wreg_loc  <= in_wreg_loc;
      out_wreg_en   <= nx_wreg_en;
      out_st_data   <= nx_st_data;
      out_mem_rd    <= mc.mem_rd;
      out_mem_wr    <= mc.mem_wr;
      out_byte_lane <= nx_lane;
      out_beat2     <= 1'b0;
      branch_taken  <= nx_taken;
    end else if (beat2_load) begin
      out_valid     <= 1'b1;
      out_result    <= beat2_addr_q;
      out_wreg_en   <= 1'b0;
      out_st_data   <= '0;
      out_mem_rd    <= 1'b0;
      out_mem_wr    <= 1'b1;
      out_byte_lane <= 1'b0;
      out_beat2     <= 1'b1;
      branch_taken  <= 1'b0;
    end else if (out_fire) begin
      out_valid    <= 1'b0;
      out_beat2    <= 1'b0;
      branch_taken <= 1'b0;
    end
  end

endmodule
